// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-side, D-side and downstream memory signals.
// The master modport is the arbiter's view; slave is the pipeline plus memory view.
interface mem_port_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D); one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN to break I/D ties by alternating instead of D priority.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t      state_reg;
  logic        owner_reg;
  logic        busy_reg;
  logic [31:0] addr_reg;
  logic [3:0]  rmask_reg;
  logic [3:0]  wmask_reg;
  logic [31:0] wdata_reg;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_owner_reg;
`endif

  logic i_pending;
  logic d_pending;
  logic d_is_store;
  logic grant_d;
  logic resp_fire;

  always_comb begin
    i_pending  = |bus.imem_rmask;
    d_is_store = |bus.dmem_wmask;
    d_pending  = (|bus.dmem_rmask) || d_is_store;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_d    = d_pending && (!i_pending || (last_owner_reg == OWNER_I));
`else
    grant_d    = d_pending;
`endif
    resp_fire  = (state_reg == WAIT) && bus.mem_resp;
  end

  // The mem_* registers are the issue registers: loaded on grant, cleared after ISSUE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= OWNER_I;
      busy_reg  <= 1'b0;
      addr_reg  <= '0;
      rmask_reg <= '0;
      wmask_reg <= '0;
      wdata_reg <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_reg <= OWNER_I;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            addr_reg  <= bus.dmem_addr;
            rmask_reg <= d_is_store ? 4'h0 : bus.dmem_rmask;
            wmask_reg <= bus.dmem_wmask;
            wdata_reg <= d_is_store ? bus.dmem_wdata : 32'h0;
            owner_reg <= OWNER_D;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
          end else if (i_pending) begin
            addr_reg  <= bus.imem_addr;
            rmask_reg <= bus.imem_rmask;
            wmask_reg <= 4'h0;
            wdata_reg <= 32'h0;
            owner_reg <= OWNER_I;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          addr_reg  <= '0;
          rmask_reg <= '0;
          wmask_reg <= '0;
          wdata_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.mem_resp) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_reg <= owner_reg;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = addr_reg;
  assign bus.mem_rmask  = rmask_reg;
  assign bus.mem_wmask  = wmask_reg;
  assign bus.mem_wdata  = wdata_reg;
  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;
  assign bus.imem_resp  = resp_fire && (owner_reg == OWNER_I);
  assign bus.dmem_resp  = resp_fire && (owner_reg == OWNER_D);
  assign busy           = busy_reg;
endmodule
